// File: rtl/muldiv_pkg.sv
// Shared constants, FSM encoding and latched-operation payload for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned ITER_COUNT = 64;
    localparam int unsigned CNT_W      = 7;

    localparam logic MULDIV_SIGN   = 1'b1;
    localparam logic MULDIV_UNSIGN = 1'b0;

    localparam logic [XLEN-1:0] DIV_ZERO_QUOT = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic            mul_en;
        logic            a_neg;
        logic            b_neg;
        logic            b_zero;
        logic [XLEN-1:0] a_raw;
    } op_t;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement; carry lets two instances negate a 128-bit value as a pair.
module muldiv_negate
    import muldiv_pkg::*;
(
    input  logic            en,
    input  logic [XLEN-1:0] data,
    input  logic            carry,
    output logic [XLEN-1:0] result
);

    assign result = en ? (~data + XLEN'(carry)) : data;

endmodule

// File: rtl/muldiv.sv
// 64-bit iterative multiplier / restoring divider with fixed 65-cycle latency.
module muldiv
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            rs1_sign_i,
    input  logic            rs2_sign_i,
    input  logic            mul_en_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] data_1_o,
    output logic [XLEN-1:0] data_2_o,
    output logic            resp_valid_o,
    output logic            busy_o
);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_t             op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [XLEN-1:0] data_1_d, data_2_d;
    logic            resp_d;

    logic            a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_neg_in = (rs1_sign_i == MULDIV_SIGN) && rs1_data_i[XLEN-1];
    assign b_neg_in = (rs2_sign_i == MULDIV_SIGN) && rs2_data_i[XLEN-1];

    muldiv_negate u_neg_a (.en(a_neg_in), .data(rs1_data_i), .carry(1'b1), .result(a_mag));
    muldiv_negate u_neg_b (.en(b_neg_in), .data(rs2_data_i), .carry(1'b1), .result(b_mag));

    // One iteration: shift-add for multiply, shift-compare-subtract for divide.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN+1:0] div_diff;
    logic            div_ge;
    logic [XLEN-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        div_ge    = ~div_diff[XLEN+1];
        if (op_q.mul_en) begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
            step_hi = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end
    end

    // Sign fixup on the final iteration's result; the high half borrows the low half's carry for products.
    logic            fix_lo_en, fix_hi_en, fix_hi_carry;
    logic [XLEN-1:0] fix_lo, fix_hi;
    logic [XLEN-1:0] res_1, res_2;

    assign fix_lo_en    = op_q.a_neg ^ op_q.b_neg;
    assign fix_hi_en    = op_q.mul_en ? (op_q.a_neg ^ op_q.b_neg) : op_q.a_neg;
    assign fix_hi_carry = op_q.mul_en ? (step_lo == '0) : 1'b1;

    muldiv_negate u_neg_lo (.en(fix_lo_en), .data(step_lo), .carry(1'b1),         .result(fix_lo));
    muldiv_negate u_neg_hi (.en(fix_hi_en), .data(step_hi), .carry(fix_hi_carry), .result(fix_hi));

    always_comb begin
        if (!op_q.mul_en && op_q.b_zero) begin
            res_1 = DIV_ZERO_QUOT;
            res_2 = op_q.a_raw;
        end else begin
            res_1 = fix_lo;
            res_2 = fix_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            b_q          <= '0;
            data_1_o     <= '0;
            data_2_o     <= '0;
            resp_valid_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            b_q          <= b_d;
            data_1_o     <= data_1_d;
            data_2_o     <= data_2_d;
            resp_valid_o <= resp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        data_1_d = data_1_o;
        data_2_d = data_2_o;
        resp_d   = 1'b0;
        busy_o   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && !flush_i) begin
                    busy_o      = 1'b1;
                    op_d.mul_en = mul_en_i;
                    op_d.a_neg  = a_neg_in;
                    op_d.b_neg  = b_neg_in;
                    op_d.b_zero = (rs2_data_i == '0);
                    op_d.a_raw  = rs1_data_i;
                    hi_d        = '0;
                    lo_d        = a_mag;
                    b_d         = b_mag;
                    cnt_d       = '0;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy_o = 1'b1;
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
                        state_d  = ST_DONE;
                        data_1_d = res_1;
                        data_2_d = res_2;
                        resp_d   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: random and corner operations against a wide-arithmetic reference model.
module tb_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic [63:0] rs1_data_i = '0;
    logic [63:0] rs2_data_i = '0;
    logic        rs1_sign_i = 1'b0;
    logic        rs2_sign_i = 1'b0;
    logic        mul_en_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [63:0] data_1_o, data_2_o;
    logic        resp_valid_o, busy_o;

    muldiv dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .rs1_sign_i(rs1_sign_i), .rs2_sign_i(rs2_sign_i),
        .mul_en_i(mul_en_i), .flush_i(flush_i),
        .data_1_o(data_1_o), .data_2_o(data_2_o),
        .resp_valid_o(resp_valid_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] d1;
        logic [63:0] d2;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: full-width product mod 2^128; truncating division on 66-bit signed values.
    function automatic logic [127:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                               input logic sa, input logic sb, input logic mul);
        logic [127:0]       ae, be;
        logic signed [65:0] av, bv, qv, rv;
        if (mul) begin
            ae = sa ? {{64{a[63]}}, a} : {64'd0, a};
            be = sb ? {{64{b[63]}}, b} : {64'd0, b};
            return ae * be;
        end
        if (b == 64'd0) return {a, 64'hFFFF_FFFF_FFFF_FFFF};
        av = sa ? $signed({{2{a[63]}}, a}) : $signed({2'b00, a});
        bv = sb ? $signed({{2{b[63]}}, b}) : $signed({2'b00, b});
        qv = av / bv;
        rv = av % bv;
        return {rv[63:0], qv[63:0]};
    endfunction

    function automatic logic [63:0] pick();
        int v;
        case ($urandom_range(0, 6))
            0: return {$urandom, $urandom};
            1: begin
                v = int'($urandom_range(0, 200)) - 100;
                return 64'(v);
            end
            2: return 64'd0;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            4: return 64'h8000_0000_0000_0000;
            5: return 64'd1;
            default: return {32'd0, $urandom};
        endcase
    endfunction

    // Monitor: pops the scoreboard on every response and checks output hold between responses.
    logic        rst_prev = 1'b1;
    logic [63:0] hold1 = '0;
    logic [63:0] hold2 = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_prev) begin
            hold1 = '0;
            hold2 = '0;
        end
        if (resp_valid_o) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid_o=1 required 0 (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("data_1", data_1_o, e.d1);
                check("data_2", data_2_o, e.d2);
                check("latency", 64'(cyc - e.acc), 64'd65);
                check("busy_in_done", {63'd0, busy_o}, 64'd0);
            end
            hold1 = data_1_o;
            hold2 = data_2_o;
        end else begin
            check("hold_1", data_1_o, hold1);
            check("hold_2", data_2_o, hold2);
        end
        rst_prev = rst;
    end

    // Drive one op; from_done means the DUT is in DONE now and accepts on the following cycle.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sa,
                          input logic sb, input logic mul, input bit from_done);
        exp_t         e;
        logic [127:0] r;
        bit           got;
        rs1_data_i  = a;
        rs2_data_i  = b;
        rs1_sign_i  = sa;
        rs2_sign_i  = sb;
        mul_en_i    = mul;
        req_valid_i = 1'b1;
        flush_i     = 1'b0;
        r     = ref_model(a, b, sa, sb, mul);
        e.d1  = r[63:0];
        e.d2  = r[127:64];
        e.acc = from_done ? cyc + 1 : cyc;
        sb_q.push_back(e);
        @(posedge clk); #1;
        if (from_done) begin
            @(posedge clk); #1;
        end
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (resp_valid_o) begin
                got = 1'b1;
                break;
            end
            check("busy_in_busy", {63'd0, busy_o}, 64'd1);
            rs1_data_i = {$urandom, $urandom};
            rs2_data_i = {$urandom, $urandom};
            rs1_sign_i = 1'($urandom_range(0, 1));
            rs2_sign_i = 1'($urandom_range(0, 1));
            mul_en_i   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_timeout: got no resp_valid_o required one within 200 cycles");
        end
    endtask

    // Abort an op at BUSY cycle 30 by flush or reset, then issue a fresh op immediately after.
    task automatic abort_test(input bit use_rst);
        int acc;
        rs1_data_i  = 64'd123456789;
        rs2_data_i  = 64'd1000;
        rs1_sign_i  = 1'b1;
        rs2_sign_i  = 1'b1;
        mul_en_i    = 1'b0;
        req_valid_i = 1'b1;
        acc = cyc + 1;
        while (cyc < acc + 30) begin
            @(posedge clk); #1;
        end
        req_valid_i = 1'b0;
        if (use_rst) rst = 1'b1;
        else flush_i = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        flush_i = 1'b0;
        check(use_rst ? "rst_busy" : "flush_busy", {63'd0, busy_o}, 64'd0);
        check(use_rst ? "rst_resp" : "flush_resp", {63'd0, resp_valid_o}, 64'd0);
        if (use_rst) begin
            check("rst_data_1", data_1_o, 64'd0);
            check("rst_data_2", data_2_o, 64'd0);
        end
        run_op(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation time limit required $finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_resp", {63'd0, resp_valid_o}, 64'd0);
        check("reset_busy", {63'd0, busy_o}, 64'd0);
        check("reset_data_1", data_1_o, 64'd0);
        check("reset_data_2", data_2_o, 64'd0);

        run_op(64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b1, 1'b1, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        run_op(64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1);

        abort_test(1'b0);
        abort_test(1'b1);

        for (int i = 0; i < 40; i++) begin
            run_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b1);
        end

        req_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 64'(sb_q.size()), 64'd0);
        check("idle_busy", {63'd0, busy_o}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
